// File: rtl/mem_stage_lsu_if.sv
// Data-SRAM request/response bus between the MEM-stage LSU and the data memory.
// req/we/be/addr/wdata are driven by the LSU and stay stable until gnt.
// rvalid/rdata return load data one or more cycles after the grant.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [NB-1:0]     be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage between EX and WB.
// Issues loads/stores over a req/gnt/rvalid SRAM bus, aligns and extends load
// data, feeds WB and the ID forwarding path, and stalls the front end while an
// access is outstanding.
// Optional build macro MEM_MISALIGN_EXC_EN: when defined, misaligned accesses
// raise misalign_exc instead of being silently aligned down.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wb_stall,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic                in_mem_en,
  input  logic                in_mem_we,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_rf_we,
  input  logic [RF_AW-1:0]    in_rf_waddr,
  input  logic [DATA_W-1:0]   in_ex_result,
  mem_stage_lsu_if.master     dmem,
  output logic                wb_valid,
  output logic [31:0]         wb_pc,
  output logic                wb_we,
  output logic [RF_AW-1:0]    wb_waddr,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                fwd_pending,
  output logic                fwd_we,
  output logic [RF_AW-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]   fwd_wdata,
  output logic                stall_req,
  output logic                misalign_exc
);
  localparam int NB = DATA_W / 8;
  localparam int LB = (DATA_W == 64) ? 3 : 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // A dword request on a 32-bit bus degrades to a word access.
  function automatic logic [1:0] clamp_size(input logic [1:0] sz);
    if ((DATA_W == 32) && (sz == 2'b11)) begin
      return 2'b10;
    end else begin
      return sz;
    end
  endfunction

  // Low address bits that must be zero for an access of this size.
  function automatic logic [LB-1:0] size_mask(input logic [1:0] sz);
    logic [LB-1:0] m;
    m = {LB{1'b0}};
    case (sz)
      2'b00:   m = {LB{1'b0}};
      2'b01:   m[0] = 1'b1;
      2'b10:   m[1:0] = 2'b11;
      default: m = {LB{1'b1}};
    endcase
    return m;
  endfunction

  // Byte enables: size-wide run of ones shifted to the byte offset.
  function automatic logic [NB-1:0] calc_be(input logic [1:0] sz, input logic [LB-1:0] low);
    logic [NB-1:0] base;
    base = {NB{1'b0}};
    case (sz)
      2'b00:   base[0] = 1'b1;
      2'b01:   base[1:0] = 2'b11;
      2'b10:   base[3:0] = 4'hF;
      default: base = {NB{1'b1}};
    endcase
    return base << low;
  endfunction

  // Store data replicated into every lane so the byte enables pick the right copy.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {NB{d[7:0]}};
      2'b01:   r = {(NB/2){d[15:0]}};
      2'b10:   r = {(NB/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Right-align the addressed lane(s), mask to size and sign/zero extend.
  function automatic logic [DATA_W-1:0] extend_load(input logic [1:0] sz, input logic sgn,
                                                    input logic [LB-1:0] low,
                                                    input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    logic              msb;
    sh = rd >> {low, 3'b000};
    case (sz)
      2'b00:   begin keep = DATA_W'(8'hFF);         msb = sh[7];  end
      2'b01:   begin keep = DATA_W'(16'hFFFF);      msb = sh[15]; end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); msb = sh[31]; end
      default: begin keep = {DATA_W{1'b1}};         msb = 1'b0;   end
    endcase
    if (sgn && msb) begin
      return sh | ~keep;
    end else begin
      return sh & keep;
    end
  endfunction

  logic [2:0]        state_r;
  logic [31:0]       pc_r;
  logic              rf_we_r;
  logic [RF_AW-1:0]  waddr_r;
  logic              mem_we_r;
  logic [1:0]        size_r;
  logic              sgn_r;
  logic [LB-1:0]     low_r;
  logic              dmem_req_r;
  logic [NB-1:0]     dmem_be_r;
  logic [ADDR_W-1:0] dmem_addr_r;
  logic [DATA_W-1:0] dmem_wdata_r;
  logic              wb_valid_r;
  logic              wb_we_r;
  logic [DATA_W-1:0] wb_wdata_r;
  logic              misalign_r;

  logic [1:0]        acc_size_s;
  logic [LB-1:0]     acc_mask_s;
  logic [LB-1:0]     acc_low_s;
  logic              misalign_s;
  logic              accept_s;

  // Decode the incoming access: effective size, aligned byte offset, misalignment.
  always_comb begin
    acc_size_s = clamp_size(in_size);
    acc_mask_s = size_mask(acc_size_s);
    acc_low_s  = in_addr[LB-1:0] & ~acc_mask_s;
`ifdef MEM_MISALIGN_EXC_EN
    misalign_s = in_mem_en & (|(in_addr[LB-1:0] & acc_mask_s));
`else
    misalign_s = 1'b0;
`endif
  end

  // Handshake and pipeline-control status derived from the current state.
  always_comb begin
    in_ready    = (state_r == S_IDLE) || ((state_r == S_DONE) && !wb_stall);
    accept_s    = in_valid && in_ready && !flush;
    stall_req   = (state_r == S_REQ) || (state_r == S_WAIT) || ((state_r == S_DONE) && wb_stall);
    fwd_pending = ((state_r == S_REQ) || (state_r == S_WAIT)) && !mem_we_r && rf_we_r;
  end

  // Stage FSM: accept, request, wait for data, hold result, or drain a killed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pc_r         <= 32'd0;
      rf_we_r      <= 1'b0;
      waddr_r      <= {RF_AW{1'b0}};
      mem_we_r     <= 1'b0;
      size_r       <= 2'b00;
      sgn_r        <= 1'b0;
      low_r        <= {LB{1'b0}};
      dmem_req_r   <= 1'b0;
      dmem_be_r    <= {NB{1'b0}};
      dmem_addr_r  <= {ADDR_W{1'b0}};
      dmem_wdata_r <= {DATA_W{1'b0}};
      wb_valid_r   <= 1'b0;
      wb_we_r      <= 1'b0;
      wb_wdata_r   <= {DATA_W{1'b0}};
      misalign_r   <= 1'b0;
    end else if (accept_s) begin
      pc_r         <= in_pc;
      rf_we_r      <= in_rf_we;
      waddr_r      <= in_rf_waddr;
      mem_we_r     <= in_mem_en & in_mem_we;
      size_r       <= acc_size_s;
      sgn_r        <= in_signed;
      low_r        <= acc_low_s;
      dmem_be_r    <= calc_be(acc_size_s, acc_low_s);
      dmem_addr_r  <= {in_addr[ADDR_W-1:LB], {LB{1'b0}}};
      dmem_wdata_r <= replicate(acc_size_s, in_wdata);
      wb_wdata_r   <= in_ex_result;
      if (!in_mem_en) begin
        state_r    <= S_DONE;
        dmem_req_r <= 1'b0;
        wb_valid_r <= 1'b1;
        wb_we_r    <= in_rf_we;
        misalign_r <= 1'b0;
      end else if (misalign_s) begin
        state_r    <= S_DONE;
        dmem_req_r <= 1'b0;
        wb_valid_r <= 1'b1;
        wb_we_r    <= 1'b0;
        misalign_r <= 1'b1;
      end else begin
        state_r    <= S_REQ;
        dmem_req_r <= 1'b1;
        wb_valid_r <= 1'b0;
        wb_we_r    <= 1'b0;
        misalign_r <= 1'b0;
      end
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          wb_valid_r <= 1'b0;
          wb_we_r    <= 1'b0;
        end
        S_REQ: begin
          if (flush && !dmem.gnt) begin
            state_r    <= S_IDLE;
            dmem_req_r <= 1'b0;
          end else if (flush) begin
            state_r    <= S_DRAIN;
            dmem_req_r <= 1'b0;
          end else if (dmem.gnt) begin
            dmem_req_r <= 1'b0;
            if (mem_we_r) begin
              state_r    <= S_DONE;
              wb_valid_r <= 1'b1;
              wb_we_r    <= 1'b0;
            end else begin
              state_r <= S_WAIT;
            end
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          if (dmem.rvalid && flush) begin
            state_r <= S_IDLE;
          end else if (dmem.rvalid) begin
            state_r    <= S_DONE;
            wb_valid_r <= 1'b1;
            wb_we_r    <= rf_we_r;
            wb_wdata_r <= extend_load(size_r, sgn_r, low_r, dmem.rdata);
          end else if (flush) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DONE: begin
          if (flush || !wb_stall) begin
            state_r    <= S_IDLE;
            wb_valid_r <= 1'b0;
            wb_we_r    <= 1'b0;
          end else begin
            state_r <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (mem_we_r || dmem.rvalid) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          dmem_req_r <= 1'b0;
          wb_valid_r <= 1'b0;
          wb_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.req     = dmem_req_r;
  assign dmem.we      = mem_we_r;
  assign dmem.be      = dmem_be_r;
  assign dmem.addr    = dmem_addr_r;
  assign dmem.wdata   = dmem_wdata_r;
  assign wb_valid     = wb_valid_r;
  assign wb_pc        = pc_r;
  assign wb_we        = wb_we_r;
  assign wb_waddr     = waddr_r;
  assign wb_wdata     = wb_wdata_r;
  assign fwd_we       = wb_we_r;
  assign fwd_waddr    = waddr_r;
  assign fwd_wdata    = wb_wdata_r;
  assign misalign_exc = misalign_r;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a 32-bit instance exercised with
// directed and random accesses against a byte-arithmetic reference model,
// plus a 64-bit instance for dword / upper-word loads.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, wb_stall = 1'b0;
  logic        in_valid = 1'b0, in_mem_en = 1'b0, in_mem_we = 1'b0, in_signed = 1'b0, in_rf_we = 1'b0;
  logic [31:0] in_pc = 32'd0, in_addr = 32'd0, in_wdata = 32'd0, in_ex_result = 32'd0;
  logic [1:0]  in_size = 2'b00;
  logic [4:0]  in_rf_waddr = 5'd0;
  logic        in_ready, wb_valid, wb_we, fwd_pending, fwd_we, stall_req, misalign_exc;
  logic [31:0] wb_pc, wb_wdata, fwd_wdata;
  logic [4:0]  wb_waddr, fwd_waddr;

  logic        q_in_valid = 1'b0;
  logic [63:0] q_in_wdata = 64'd0, q_in_ex_result = 64'd0;
  logic        q_in_ready, q_wb_valid, q_wb_we, q_fwd_pending, q_fwd_we, q_stall_req, q_misalign_exc;
  logic [31:0] q_wb_pc;
  logic [63:0] q_wb_wdata, q_fwd_wdata;
  logic [4:0]  q_wb_waddr, q_fwd_waddr;

  int checks = 0;
  int failures = 0;

  mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32)) dif ();
  mem_stage_lsu_if #(.DATA_W(64), .ADDR_W(32)) qif ();

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_ex_result(in_ex_result), .dmem(dif.master), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .fwd_pending(fwd_pending), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .stall_req(stall_req), .misalign_exc(misalign_exc));

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .RF_AW(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .in_pc(in_pc), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(q_in_wdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_ex_result(q_in_ex_result), .dmem(qif.master), .wb_valid(q_wb_valid), .wb_pc(q_wb_pc), .wb_we(q_wb_we),
    .wb_waddr(q_wb_waddr), .wb_wdata(q_wb_wdata), .fwd_pending(q_fwd_pending), .fwd_we(q_fwd_we),
    .fwd_waddr(q_fwd_waddr), .fwd_wdata(q_fwd_wdata), .stall_req(q_stall_req), .misalign_exc(q_misalign_exc));

  // ---------------- reference model (32-bit bus) ----------------
  function automatic int eff_off(input int sz, input logic [31:0] addr);
    int nb, off;
    nb  = 1 << sz;
    off = int'(addr % 32'd4);
    return off - (off % nb);
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sgn, input logic [31:0] addr, input logic [31:0] rdat);
    logic [63:0] v;
    int nb;
    nb = 1 << sz;
    v = 64'(rdat >> (8 * eff_off(sz, addr)));
    v = v % (64'd1 << (8 * nb));
    if (sgn && v >= (64'd1 << (8 * nb - 1))) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] addr);
    int b;
    b = ((1 << (1 << sz)) - 1) << eff_off(sz, addr);
    return 4'(b);
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = 1 << sz;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % nb))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  // ---------------- generic single-access driver/checker ----------------
  task automatic run_op(input string tag, input bit mem, input bit st, input int sz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                        input logic [31:0] exres, input int gd, input int rdly, input bit rfwe,
                        input logic [4:0] rd);
    bit ld, exp_we;
    logic [31:0] pcv, exp_d;
    ld = mem && !st;
    exp_we = rfwe && !(mem && st);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s ready_idle got=%b exp=1", tag, in_ready); end
    pcv = $urandom;
    in_valid = 1'b1; in_pc = pcv; in_mem_en = mem; in_mem_we = st; in_size = 2'(sz); in_signed = sgn;
    in_addr = addr; in_wdata = wdat; in_rf_we = rfwe; in_rf_waddr = rd; in_ex_result = exres;
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_ex_result = $urandom; in_rf_waddr = 5'($urandom);
    if (mem) begin
      for (int k = 0; k <= gd; k++) begin
        checks++;
        if (dif.req !== 1'b1 || dif.we !== st || dif.addr !== (addr & 32'hFFFF_FFFC)) begin
          failures++; $display("FAIL %s req got req=%b we=%b addr=%h exp req=1 we=%b addr=%h", tag, dif.req, dif.we, dif.addr, st, addr & 32'hFFFF_FFFC);
        end
        checks++; if (dif.be !== m_be(sz, addr)) begin failures++; $display("FAIL %s be got=%b exp=%b", tag, dif.be, m_be(sz, addr)); end
        if (st) begin
          checks++; if (dif.wdata !== m_wdata(sz, wdat)) begin failures++; $display("FAIL %s wdata got=%h exp=%h", tag, dif.wdata, m_wdata(sz, wdat)); end
        end
        checks++;
        if (stall_req !== 1'b1 || wb_valid !== 1'b0 || fwd_pending !== (ld && rfwe)) begin
          failures++; $display("FAIL %s req_phase got stall=%b wbv=%b pend=%b exp 1 0 %b", tag, stall_req, wb_valid, fwd_pending, ld && rfwe);
        end
        if (ld && rfwe) begin
          checks++; if (fwd_waddr !== rd || fwd_we !== 1'b0) begin failures++; $display("FAIL %s fwd_pend got waddr=%0d we=%b exp %0d 0", tag, fwd_waddr, fwd_we, rd); end
        end
        dif.gnt = (k == gd);
        @(negedge clk);
      end
      dif.gnt = 1'b0;
      if (ld) begin
        for (int k = 0; k <= rdly; k++) begin
          checks++;
          if (dif.req !== 1'b0 || stall_req !== 1'b1 || wb_valid !== 1'b0 || fwd_pending !== rfwe) begin
            failures++; $display("FAIL %s wait_phase got req=%b stall=%b wbv=%b pend=%b exp 0 1 0 %b", tag, dif.req, stall_req, wb_valid, fwd_pending, rfwe);
          end
          dif.rvalid = (k == rdly);
          dif.rdata = (k == rdly) ? rdat : $urandom;
          @(negedge clk);
        end
        dif.rvalid = 1'b0;
      end
    end
    exp_d = mem ? m_load(sz, sgn, addr, rdat) : exres;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== exp_we || wb_pc !== pcv || wb_waddr !== rd) begin
      failures++; $display("FAIL %s wb_ctl got v=%b we=%b pc=%h wa=%0d exp 1 %b %h %0d", tag, wb_valid, wb_we, wb_pc, wb_waddr, exp_we, pcv, rd);
    end
    if (!(mem && st)) begin
      checks++;
      if (wb_wdata !== exp_d || fwd_wdata !== exp_d) begin
        failures++; $display("FAIL %s wb_wdata got=%h fwd=%h exp=%h", tag, wb_wdata, fwd_wdata, exp_d);
      end
    end
    checks++;
    if (fwd_we !== exp_we || stall_req !== 1'b0 || misalign_exc !== 1'b0 || dif.req !== 1'b0) begin
      failures++; $display("FAIL %s done_misc got fwd_we=%b stall=%b mis=%b req=%b exp %b 0 0 0", tag, fwd_we, stall_req, misalign_exc, dif.req, exp_we);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dif.req, wb_valid, wb_we, stall_req, misalign_exc, fwd_pending, fwd_we, in_ready} !== 8'b0000_0001) begin
      failures++; $display("FAIL reset_ctl got req=%b wbv=%b we=%b stall=%b mis=%b pend=%b fwe=%b rdy=%b", dif.req, wb_valid, wb_we, stall_req, misalign_exc, fwd_pending, fwd_we, in_ready);
    end
    checks++;
    if (wb_pc !== 32'd0 || wb_wdata !== 32'd0 || wb_waddr !== 5'd0 || fwd_wdata !== 32'd0 || fwd_waddr !== 5'd0) begin
      failures++; $display("FAIL reset_data got pc=%h wd=%h wa=%0d fwd=%h fwa=%0d exp all 0", wb_pc, wb_wdata, wb_waddr, fwd_wdata, fwd_waddr);
    end
    checks++;
    if ({qif.req, q_wb_valid, q_wb_we, q_stall_req, q_misalign_exc, q_fwd_pending, q_fwd_we} !== 7'd0 || q_wb_wdata !== 64'd0 || q_fwd_wdata !== 64'd0 || q_wb_pc !== 32'd0 || q_wb_waddr !== 5'd0 || q_fwd_waddr !== 5'd0 || q_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_64 got req=%b wbv=%b wd=%h exp 0 0 0", qif.req, q_wb_valid, q_wb_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("lb_0x103",  1'b1, 1'b0, 0, 1'b1, 32'h103, 32'd0, 32'h80FF_0000, 32'd0, 0, 0, 1'b1, 5'd4);
    run_op("lhu_0x102", 1'b1, 1'b0, 1, 1'b0, 32'h102, 32'd0, 32'hBEEF_1234, 32'd0, 0, 0, 1'b1, 5'd5);
    run_op("sh_0x202",  1'b1, 1'b1, 1, 1'b0, 32'h202, 32'h0000_1234, 32'd0, 32'd0, 0, 0, 1'b0, 5'd0);
    run_op("alu",       1'b0, 1'b0, 2, 1'b0, 32'd0, 32'd0, 32'd0, 32'hCAFE_F00D, 0, 0, 1'b1, 5'd6);
  endtask

  task automatic test_slow_memory();
    run_op("lw_slow", 1'b1, 1'b0, 2, 1'b1, 32'h300, 32'd0, 32'h8765_4321, 32'd0, 3, 2, 1'b1, 5'd7);
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_EXC_EN
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h0000_4444; in_mem_en = 1'b1; in_mem_we = 1'b0; in_size = 2'b10;
    in_addr = 32'h101; in_rf_we = 1'b1; in_rf_waddr = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (dif.req !== 1'b0 || misalign_exc !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_pc !== 32'h0000_4444) begin
      failures++; $display("FAIL misalign got req=%b mis=%b wbv=%b we=%b pc=%h exp 0 1 1 0 00004444", dif.req, misalign_exc, wb_valid, wb_we, wb_pc);
    end
    @(negedge clk);
    checks++; if (dif.req !== 1'b0 || misalign_exc !== 1'b0) begin failures++; $display("FAIL misalign_after got req=%b mis=%b exp 0 0", dif.req, misalign_exc); end
`else
    run_op("lw_0x101", 1'b1, 1'b0, 2, 1'b0, 32'h101, 32'd0, 32'h1357_9BDF, 32'd0, 0, 0, 1'b1, 5'd8);
`endif
  endtask

  task automatic test_flush_wait();
    @(negedge clk);
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_size = 2'b10; in_addr = 32'h40; in_rf_we = 1'b1; in_rf_waddr = 5'd3;
    @(negedge clk); in_valid = 1'b0; dif.gnt = 1'b1;
    @(negedge clk); dif.gnt = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_wait_drain got wbv=%b rdy=%b exp 0 0", wb_valid, in_ready); end
    @(negedge clk); dif.rvalid = 1'b1; dif.rdata = $urandom;
    @(negedge clk); dif.rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_wait_idle got wbv=%b rdy=%b exp 0 1", wb_valid, in_ready); end
    in_valid = 1'b1; in_mem_en = 1'b0; in_ex_result = 32'h0BAD_CAFE; in_rf_waddr = 5'd9;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_wdata !== 32'h0BAD_CAFE) begin failures++; $display("FAIL flush_wait_next got wbv=%b wd=%h exp 1 0badcafe", wb_valid, wb_wdata); end
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b1; in_size = 2'b00; in_addr = 32'h55; in_wdata = 32'hAB;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (dif.req !== 1'b1) begin failures++; $display("FAIL flush_req_pre got req=%b exp 1", dif.req); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (dif.req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL flush_req got req=%b rdy=%b wbv=%b exp 0 1 0", dif.req, in_ready, wb_valid); end
  endtask

  task automatic test_stall_and_flush_done();
    @(negedge clk);
    in_valid = 1'b1; in_mem_en = 1'b0; in_ex_result = 32'h1111_2222; in_rf_we = 1'b1;
    @(negedge clk); wb_stall = 1'b1; in_ex_result = 32'h3333_4444;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h1111_2222 || in_ready !== 1'b0 || stall_req !== 1'b1) begin
      failures++; $display("FAIL wb_stall_hold got wbv=%b wd=%h rdy=%b stall=%b exp 1 11112222 0 1", wb_valid, wb_wdata, in_ready, stall_req);
    end
    wb_stall = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_wdata !== 32'h3333_4444) begin failures++; $display("FAIL back_to_back got wbv=%b wd=%h exp 1 33334444", wb_valid, wb_wdata); end
    wb_stall = 1'b1; flush = 1'b1;
    @(negedge clk); flush = 1'b0; wb_stall = 1'b0;
    checks++; if (wb_valid !== 1'b0 || stall_req !== 1'b0) begin failures++; $display("FAIL flush_done got wbv=%b stall=%b exp 0 0", wb_valid, stall_req); end
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || dif.req !== 1'b0) begin failures++; $display("FAIL flush_vs_valid got wbv=%b req=%b exp 0 0", wb_valid, dif.req); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_size = 2'b10; in_addr = 32'h80; in_rf_we = 1'b1;
    @(negedge clk); in_valid = 1'b0; dif.gnt = 1'b1;
    @(negedge clk); dif.gnt = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (dif.req !== 1'b0 || stall_req !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid got req=%b stall=%b rdy=%b exp 0 0 1", dif.req, stall_req, in_ready); end
    dif.rvalid = 1'b1; dif.rdata = 32'hDEAD_BEEF;
    @(negedge clk); dif.rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_rvalid got wbv=%b exp 0", wb_valid); end
  endtask

  task automatic test_random();
    bit mem, st, sgn, rfwe;
    int sz;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      mem  = ($urandom_range(0, 3) != 0);
      st   = mem && ($urandom_range(0, 1) == 1);
      sgn  = ($urandom_range(0, 1) == 1);
      rfwe = ($urandom_range(0, 1) == 1);
      sz   = $urandom_range(0, 2);
      addr = $urandom;
`ifdef MEM_MISALIGN_EXC_EN
      addr = addr & ~(32'(1 << sz) - 32'd1);
`endif
      run_op($sformatf("rnd%0d", i), mem, st, sz, sgn, addr, $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), rfwe, 5'($urandom));
    end
  endtask

  task automatic test_dword();
    logic [63:0] rd64, exp64;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rd64 = {$urandom, $urandom};
      q_in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_signed = 1'b1; in_rf_we = 1'b1; in_rf_waddr = 5'd10;
      in_size = (c == 0) ? 2'b11 : 2'b10;
      in_addr = (c == 0) ? 32'h8 : 32'hC;
      @(negedge clk); q_in_valid = 1'b0;
      checks++;
      if (qif.req !== 1'b1 || qif.addr !== 32'h8 || qif.be !== ((c == 0) ? 8'hFF : 8'hF0)) begin
        failures++; $display("FAIL d64_req%0d got req=%b addr=%h be=%h", c, qif.req, qif.addr, qif.be);
      end
      qif.gnt = 1'b1;
      @(negedge clk); qif.gnt = 1'b0; qif.rvalid = 1'b1; qif.rdata = rd64;
      @(negedge clk); qif.rvalid = 1'b0;
      exp64 = (c == 0) ? rd64 : {{32{rd64[63]}}, rd64[63:32]};
      checks++;
      if (q_wb_valid !== 1'b1 || q_wb_wdata !== exp64) begin
        failures++; $display("FAIL d64_wb%0d got v=%b wd=%h exp 1 %h", c, q_wb_valid, q_wb_wdata, exp64);
      end
    end
  endtask

  initial begin
    dif.gnt = 1'b0; dif.rvalid = 1'b0; dif.rdata = 32'd0;
    qif.gnt = 1'b0; qif.rvalid = 1'b0; qif.rdata = 64'd0;
    test_reset();
    test_directed();
    test_slow_memory();
    test_misalign();
    test_flush_wait();
    test_flush_req();
    test_stall_and_flush_done();
    test_reset_mid();
    test_random();
    test_dword();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised memory-access pipeline stage; sits between EX and WB.
- Successor to the fixed single-cycle MEM stage: issues loads/stores over a req/gnt/rvalid data-SRAM handshake with variable latency.
- Aligns and extends load data for any byte/half/word(/dword) size.
- Drives WB and the ID forwarding path; requests a pipeline stall while an access is outstanding.

Parameters:
- DATA_W, 32, data-bus width; 32 or 64. Lanes NB = DATA_W/8.
- ADDR_W, 32, byte address width.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- flush  in  1  kill the instruction held in this stage
- wb_stall  in  1  downstream cannot accept this cycle
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  32  instruction PC
- in_mem_en  in  1  instruction is a load/store
- in_mem_we  in  1  1 = store, 0 = load
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
- in_signed  in  1  sign-extend load data
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data, right-aligned
- in_rf_we  in  1  register write enable
- in_rf_waddr  in  RF_AW  destination register
- in_ex_result  in  DATA_W  ALU result, used when not a load
- dmem_req  out  1  request
- dmem_gnt  in  1  request accepted
- dmem_we  out  1  write
- dmem_be  out  NB  byte enables
- dmem_addr  out  ADDR_W  address, aligned to DATA_W
- dmem_wdata  out  DATA_W  lane-replicated store data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data
- wb_valid  out  1  result valid to WB
- wb_pc  out  32  PC
- wb_we  out  1  register write enable
- wb_waddr  out  RF_AW  destination register
- wb_wdata  out  DATA_W  writeback data
- fwd_pending  out  1  load in flight; ID must stall on a match with fwd_waddr
- fwd_we  out  1  forwarding write enable
- fwd_waddr  out  RF_AW  forwarding address
- fwd_wdata  out  DATA_W  forwarding data
- stall_req  out  1  freeze IF/ID/EX
- misalign_exc  out  1  see Optional Feature

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE and zeroes every output register.
- After reset: dmem_req=0, wb_valid=0, wb_*=0, fwd_*=0, stall_req=0, misalign_exc=0.
- Reset mid-access returns to IDLE immediately. Any later rvalid is ignored.
- Handshake: in_ready = (state==IDLE) | (state==DONE & !wb_stall). Transfer occurs on in_valid & in_ready.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- Non-memory instruction: goes directly to DONE; wb_wdata=in_ex_result. Latency 1 cycle.
- Memory instruction: goes to REQ; dmem_req=1, fields registered. All request fields are held stable until dmem_gnt.
- REQ + gnt, store: go to DONE with wb_we=0; no rvalid is expected.
- REQ + gnt, load: go to WAIT.
- WAIT + rvalid: go to DONE. Capture rdata >> (8*addr_low), mask to size, extend (sign if in_signed, else zero).
- Minimum load latency: accept edge T, then req in cycle T+1 with same-cycle gnt, then rvalid in T+2, then wb_valid in T+3.
- DONE: wb_valid=1. Leave on transfer (to next instruction) or, if no new transfer, to IDLE when !wb_stall.
- dmem_be: size-wide mask shifted by addr_low. dmem_wdata: in_wdata replicated across lanes.
- stall_req = 1 in REQ and WAIT, or when in DONE with wb_stall.
- fwd_pending = 1 in REQ/WAIT for a load with rf_we. In that case fwd_waddr is valid and fwd_we=0.
- In DONE: fwd_we=wb_we, fwd_wdata=wb_wdata.
- Flush in IDLE/DONE: drop the held result (wb_valid=0 next cycle).
- Flush in REQ, not granted: drop the request, go to IDLE.
- Flush in REQ + gnt, or in WAIT: go to DRAIN. DRAIN absorbs one rvalid (store: none), then goes to IDLE. No writeback occurs.
- Simultaneous flush and in_valid: flush wins; nothing is accepted.

Optional Feature:
- Macro MEM_MISALIGN_EXC_EN.
- Defined: an access with addr_low not a multiple of the size issues no request. The stage goes to DONE with wb_we=0 and misalign_exc=1 for one cycle, with wb_pc valid.
- Undefined: misalign_exc tied to 0. Address low bits below the size are cleared (forced alignment) and the access proceeds normally.

Test Plan:
- DATA_W=32: lb addr 0x103, rdata 0x80FF_0000, gnt same cycle, rvalid +1 -> wb_wdata=0xFFFF_FF80, wb_valid 3 cycles after accept.
- lhu addr 0x102, rdata 0xBEEF_1234 -> wb_wdata=0x0000_BEEF.
- sh addr 0x202, wdata 0x1234 -> dmem_be=4'b1100, dmem_wdata=0x1234_1234, wb_we=0.
- gnt withheld 3 cycles then rvalid delayed 2 -> stall_req high throughout, dmem_addr stable, fwd_pending=1 with fwd_waddr=rd.
- Flush in WAIT, then rvalid -> no wb_valid; next instruction accepted the cycle after DRAIN.
- MEM_MISALIGN_EXC_EN, lw addr 0x101 -> dmem_req never asserts, misalign_exc=1, wb_we=0. Without macro -> request to address 0x100.
- DATA_W=64: ld addr 0x8 -> dmem_be=8'hFF, full 64-bit writeback.
